cover_toggle_drainer: RTL
=========================

# cover_toggle_drainer

Sticky collector and serializer for a WIDTH-bit group of toggle-coverage hit strobes. It records the first hit of every bit and emits each newly covered global cover index exactly once over a valid/ready stream. The stream can be consumed by a single shared DPI reporter, a trace buffer or a formal monitor in place of per-bit calls. It sits beside the toggle instrumentation of one signal group, one instance per group.

## Interface
- WIDTH, 39, number of toggle bits in the group
- COVER_INDEX, 0, global cover index of bit 0
- COVER_TOTAL, 38253, total cover points; elaboration error if COVER_INDEX+WIDTH > COVER_TOTAL
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears all state immediately
- valid  in  WIDTH  per-bit hit strobes, sampled every cycle
- clear  in  1  single-cycle request to forget all coverage (new test phase)
- out_valid  out  1  out_index holds a newly covered index
- out_ready  in  1  consumer accepts; transfer ("fire") = out_valid & out_ready
- out_index  out  64  COVER_INDEX + bit position
- idle  out  1  no pending bits and out_valid low
- reported  out  16  count of fires since reset/clear, saturating at 0xFFFF

## Operation
- State: seen[WIDTH] (covered ever), pending[WIDTH] (covered, not yet emitted), hold register (out_valid, out_index), reported counter.
- Per cycle, without clear: new = valid & ~seen; seen <= seen | valid; pending <= (pending | new) & ~take, where take is the one-hot bit loaded into hold this cycle.
- Hold FSM, two states:
  - EMPTY (out_valid=0): if pending != 0, load the lowest set pending bit → FULL.
  - FULL (out_valid=1): out_index stable until fire. On fire, load the next lowest pending bit and stay FULL; if none, → EMPTY.
  - Loads use registered pending only. A bit arriving in valid this cycle is not eligible until the next cycle.
- Selection is the lowest index first. Each bit is emitted at most once between clears.
- A hit on a bit that is already seen, pending, or currently in hold is ignored.
- clear:
  - seen <= valid and pending <= valid, i.e. hits in the clear cycle count as first hits of the new phase.
  - reported <= 0.
  - The beat in hold is not dropped; it stays until fired. That fire does not increment the freshly cleared counter.
  - No load from the old pending occurs in the clear cycle.
- reported increments on every fire except as stated for clear; it holds at 0xFFFF.
- idle = (pending == 0) & ~out_valid.

## Timing
- Reset values: out_valid=0, out_index=0, idle=1, reported=0, seen=0, pending=0, FSM=EMPTY.
- Latency: hit sampled at edge t, pending at t, hold loaded at t+1, out_valid visible after edge t+1 (2 cycles from strobe to out_valid) when hold is EMPTY.
- Throughput: one index per cycle with out_ready held high, back-to-back with no bubble.
- out_ready may toggle freely. out_valid never drops without a fire, except on reset.
- All WIDTH bits hit at once: WIDTH consecutive beats, indices ascending.
- Reset asserted mid-drain: all pending and hold content is lost, outputs return to reset values asynchronously, and nothing is re-emitted after release.
- valid is ignored while reset is asserted.

## Structure
- Package cover_pkg:
  - COVER_IDX_W = 64
  - hold-state enum {HOLD_EMPTY, HOLD_FULL}
  - REPORTED_W = 16
- Sub-module cover_prio_enc: combinational lowest-set-bit finder, WIDTH in; outputs found, bit position, one-hot take. Reused by other drainer variants.

## Test plan
- Reset release, valid=0 for 10 cycles → out_valid=0, idle=1, reported=0 throughout.
- valid=bit 5 pulse at cycle 0, out_ready=1, COVER_INDEX=100 → out_valid at cycle 2 with out_index=105, one beat only; repeat the pulse → no further beat; reported=1.
- valid=all ones for one cycle, out_ready=1 → 39 consecutive beats, indices COVER_INDEX..COVER_INDEX+38, reported=39, then idle=1.
- Same as above with out_ready random 50% → out_index stable while stalled, no loss or duplicate, ordering ascending.
- Hold holds index 3 with out_ready=0, pending={7}; pulse clear with valid=bit 3 → index 3 still delivered once, then index 3 delivered again (new phase), index 7 never delivered, reported=1 at end.
- Drain of 20 bits in progress, assert reset for 1 cycle mid-stream → out_valid=0 immediately, no beats after release until new hits.

Source files
------------

// File: rtl/cover_toggle_drainer_pkg.sv
// Shared types and widths for the toggle-coverage drainer family.
package cover_pkg;

  localparam int unsigned COVER_IDX_W = 64;
  localparam int unsigned REPORTED_W  = 16;

  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_e;

  function automatic int unsigned pos_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cover_toggle_drainer_prio_enc.sv
// Lowest-set-bit finder: reports whether any bit is set, its position and a one-hot mask.
module cover_prio_enc
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned POS_W = pos_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             found_o,
  output logic [POS_W-1:0] pos_o,
  output logic [WIDTH-1:0] onehot_o
);

  // lower_any[k] is set when any of req_i[k-1:0] is set
  logic [WIDTH:0] lower_any;

  assign lower_any[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    assign lower_any[gi+1] = lower_any[gi] | req_i[gi];
    assign onehot_o[gi]    = req_i[gi] & ~lower_any[gi];
  end

  assign found_o = lower_any[WIDTH];

  always_comb begin
    pos_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) pos_o = POS_W'(i);
    end
  end

endmodule

// File: rtl/cover_toggle_drainer.sv
// Sticky first-hit collector for a group of toggle strobes; streams each newly
// covered global cover index once over valid/ready, lowest index first.
module cover_toggle_drainer
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 39,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 38253
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH-1:0]       valid_i,
  input  logic                   clear_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [COVER_IDX_W-1:0] out_index_o,
  output logic                   idle_o,
  output logic [REPORTED_W-1:0]  reported_o
);

  localparam int unsigned POS_W = pos_width(WIDTH);

  if (64'(COVER_INDEX) + 64'(WIDTH) > 64'(COVER_TOTAL)) begin : g_bad_range
    $error("cover_toggle_drainer: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  hold_state_e            state_q;
  logic [WIDTH-1:0]       seen_q;
  logic [WIDTH-1:0]       pending_q;
  logic [COVER_IDX_W-1:0] out_index_q;
  logic [REPORTED_W-1:0]  reported_q;
  // Hold carries a beat from before the last clear; its fire is not counted.
  logic                   stale_q;

  logic                   fire;
  logic                   can_load;
  logic                   load;
  logic                   found;
  logic [POS_W-1:0]       pos;
  logic [WIDTH-1:0]       onehot;
  logic [WIDTH-1:0]       take;
  logic [WIDTH-1:0]       new_hits;

  cover_prio_enc #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_prio_enc (
    .req_i    (pending_q),
    .found_o  (found),
    .pos_o    (pos),
    .onehot_o (onehot)
  );

  assign fire     = (state_q == HOLD_FULL) & out_ready_i;
  assign can_load = ~clear_i & ((state_q == HOLD_EMPTY) | fire);
  assign load     = can_load & found;
  assign take     = load ? onehot : '0;
  assign new_hits = valid_i & ~seen_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HOLD_EMPTY;
      seen_q      <= '0;
      pending_q   <= '0;
      out_index_q <= '0;
      reported_q  <= '0;
      stale_q     <= 1'b0;
    end else if (clear_i) begin
      seen_q     <= valid_i;
      pending_q  <= valid_i;
      reported_q <= '0;
      if (fire) begin
        state_q <= HOLD_EMPTY;
        stale_q <= 1'b0;
      end else if (state_q == HOLD_FULL) begin
        stale_q <= 1'b1;
      end
    end else begin
      seen_q    <= seen_q | valid_i;
      pending_q <= (pending_q | new_hits) & ~take;
      if (fire) begin
        stale_q <= 1'b0;
        if (!stale_q && reported_q != {REPORTED_W{1'b1}}) reported_q <= reported_q + 1'b1;
      end
      if (load) begin
        state_q     <= HOLD_FULL;
        out_index_q <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(pos);
      end else if (fire) begin
        state_q <= HOLD_EMPTY;
      end
    end
  end

  assign out_valid_o = (state_q == HOLD_FULL);
  assign out_index_o = out_index_q;
  assign reported_o  = reported_q;
  assign idle_o      = (pending_q == '0) & (state_q == HOLD_EMPTY);

endmodule
